// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: next-PC selection, single-level exception
// entry/return, and a one-cycle flush pulse whenever the fetch stream redirects.
module fetch_ctrl #(
  parameter int unsigned    N          = 64,
  parameter logic [N-1:0]   EXC_VECTOR = N'(64'hD8)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_target,
  input  logic         exc_req,
  input  logic [3:0]   exc_cause,
  input  logic [N-1:0] exc_pc,
  input  logic         eret,
  output logic [N-1:0] pc,
  output logic [5:0]   imem_addr,
  output logic [N-1:0] elr,
  output logic [3:0]   esr,
  output logic         in_handler,
  output logic         flush
);

  typedef enum logic {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } state_t;

  state_t state;

  // Word address straight from the registered PC so instruction data is
  // available in the same cycle the PC is presented.
  assign imem_addr = pc[7:2];

  // PC, exception registers and mode; exceptions only enter from RUN and
  // ERET only returns from HANDLER, so the two never compete in one state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      pc         <= '0;
      elr        <= '0;
      esr        <= '0;
      in_handler <= 1'b0;
      flush      <= 1'b0;
    end else begin
      flush <= 1'b0;
      if (state == RUN && exc_req) begin
        state      <= HANDLER;
        in_handler <= 1'b1;
        pc         <= EXC_VECTOR;
        elr        <= exc_pc;
        esr        <= exc_cause;
        flush      <= 1'b1;
      end else if (state == HANDLER && eret) begin
        state      <= RUN;
        in_handler <= 1'b0;
        pc         <= elr;
        flush      <= 1'b1;
      end else if (branch_taken) begin
        pc    <= branch_target;
        flush <= 1'b1;
      end else if (!stall) begin
        pc <= pc + N'(4);
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a stimulus process drives inputs and pushes
// the reference model's expected post-edge state; a monitor pops and compares.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, exc_req, eret;
  logic [63:0] branch_target, exc_pc;
  logic [3:0]  exc_cause;
  logic [63:0] pc, elr;
  logic [5:0]  imem_addr;
  logic [3:0]  esr;
  logic        in_handler, flush;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] elr;
    logic [3:0]  esr;
    logic        h;
    logic        fl;
  } exp_t;

  exp_t q[$];

  // reference model state (value after the most recent clock edge)
  logic [63:0] m_pc  = '0;
  logic [63:0] m_elr = '0;
  logic [3:0]  m_esr = '0;
  logic        m_h   = 1'b0;

  fetch_ctrl #(.N(64), .EXC_VECTOR(64'hD8)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .exc_req(exc_req), .exc_cause(exc_cause),
    .exc_pc(exc_pc), .eret(eret), .pc(pc), .imem_addr(imem_addr), .elr(elr),
    .esr(esr), .in_handler(in_handler), .flush(flush)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model by the priority rules and
  // queue what the DUT must show after the coming rising edge.
  task automatic cycle(input logic rst, input logic stl, input logic br,
                       input logic [63:0] tgt, input logic ex,
                       input logic [3:0] cause, input logic [63:0] epc,
                       input logic er);
    exp_t e;
    logic fl;
    @(negedge clk);
    reset = rst; stall = stl; branch_taken = br; branch_target = tgt;
    exc_req = ex; exc_cause = cause; exc_pc = epc; eret = er;
    fl = 1'b0;
    if (rst) begin
      m_pc = 0; m_elr = 0; m_esr = 0; m_h = 0;
    end else if (!m_h && ex) begin
      m_elr = epc; m_esr = cause; m_pc = 64'hD8; m_h = 1; fl = 1;
    end else if (m_h && er) begin
      m_pc = m_elr; m_h = 0; fl = 1;
    end else if (br) begin
      m_pc = tgt; fl = 1;
    end else if (!stl) begin
      m_pc = m_pc + 64'd4;
    end
    e.pc = m_pc; e.elr = m_elr; e.esr = m_esr; e.h = m_h; e.fl = fl;
    q.push_back(e);
  endtask

  task automatic idle(input logic stl);
    cycle(1'b0, stl, 1'b0, 64'h0, 1'b0, 4'h0, 64'h0, 1'b0);
  endtask

  // Monitor: after every rising edge with an outstanding expectation, compare.
  initial begin
    exp_t e;
    logic [5:0] ea;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e  = q.pop_front();
        ea = 6'((e.pc >> 2) % 64);
        checks += 6;
        if (pc !== e.pc) begin
          failures++; $display("FAIL pc got=%h exp=%h t=%0t", pc, e.pc, $time);
        end
        if (imem_addr !== ea) begin
          failures++; $display("FAIL imem_addr got=%0d exp=%0d t=%0t", imem_addr, ea, $time);
        end
        if (elr !== e.elr) begin
          failures++; $display("FAIL elr got=%h exp=%h t=%0t", elr, e.elr, $time);
        end
        if (esr !== e.esr) begin
          failures++; $display("FAIL esr got=%h exp=%h t=%0t", esr, e.esr, $time);
        end
        if (in_handler !== e.h) begin
          failures++; $display("FAIL in_handler got=%b exp=%b t=%0t", in_handler, e.h, $time);
        end
        if (flush !== e.fl) begin
          failures++; $display("FAIL flush got=%b exp=%b t=%0t", flush, e.fl, $time);
        end
      end
    end
  end

  initial begin
    logic [63:0] tgt;
    int unsigned r;
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    exc_req = 1'b0; exc_cause = '0; exc_pc = '0; eret = 1'b0;

    // reset, then free-running fetch
    cycle(1, 0, 0, 64'h0, 0, 4'h0, 64'h0, 0);
    repeat (4) idle(0);
    // move to 0x40, take an exception under stall
    cycle(0, 0, 1, 64'h40, 0, 4'h0, 64'h0, 0);
    cycle(0, 1, 0, 64'h0, 1, 4'h3, 64'h44, 0);
    // nested request ignored, then return
    cycle(0, 0, 0, 64'h0, 1, 4'h5, 64'h99, 0);
    idle(1);
    cycle(0, 0, 0, 64'h0, 0, 4'h0, 64'h0, 1);
    // eret in RUN ignored; both in RUN -> exception wins
    cycle(0, 0, 0, 64'h0, 0, 4'h0, 64'h0, 1);
    cycle(0, 0, 0, 64'h0, 1, 4'h7, 64'h123, 1);
    // both in HANDLER -> eret wins
    cycle(0, 0, 1, 64'h500, 1, 4'h9, 64'h77, 1);
    // branch with stall, then stall holds
    cycle(0, 1, 1, 64'h80, 0, 4'h0, 64'h0, 0);
    repeat (3) idle(1);
    // wrap at top of address space, unaligned target
    cycle(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 4'h0, 64'h0, 0);
    idle(0);
    idle(0);
    cycle(0, 0, 1, 64'h3, 0, 4'h0, 64'h0, 0);
    idle(0);
    // reset inside handler with exc_req asserted
    cycle(0, 0, 0, 64'h0, 1, 4'hA, 64'hBEEF, 0);
    cycle(1, 0, 0, 64'h0, 1, 4'hB, 64'hCAFE, 0);
    idle(0);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 99);
      tgt = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      cycle(r < 2, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, tgt,
            $urandom_range(0, 9) == 0, 4'($urandom), {$urandom, $urandom},
            $urandom_range(0, 4) == 0);
    end

    @(negedge clk);
    reset = 1'b0; stall = 1'b1; branch_taken = 1'b0; exc_req = 1'b0; eret = 1'b0;
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 64, giving the PC/address width.
REQ-002 The block SHALL have parameter EXC_VECTOR, default 64'hD8, giving the exception handler entry PC.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock, rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit, reset; one clock, synchronous, active-high.
REQ-005 The block SHALL have port stall, input, 1 bit, hold PC (hazard stall).
REQ-006 The block SHALL have port branch_taken, input, 1 bit, redirect to branch_target.
REQ-007 The block SHALL have port branch_target, input, N bits, branch destination PC.
REQ-008 The block SHALL have port exc_req, input, 1 bit, exception request from pipeline.
REQ-009 The block SHALL have port exc_cause, input, 4 bits, exception cause code.
REQ-010 The block SHALL have port exc_pc, input, N bits, PC of the faulting instruction.
REQ-011 The block SHALL have port eret, input, 1 bit, ERET executed.
REQ-012 The block SHALL have port pc, output, N bits, current fetch PC (registered).
REQ-013 The block SHALL have port imem_addr, output, 6 bits, word address to instruction memory, equal to pc[7:2].
REQ-014 The block SHALL have port elr, output, N bits, exception link register.
REQ-015 The block SHALL have port esr, output, 4 bits, exception syndrome (cause).
REQ-016 The block SHALL have port in_handler, output, 1 bit, high while in state HANDLER.
REQ-017 The block SHALL have port flush, output, 1 bit, one-cycle pulse on any redirect.

Function
REQ-018 The FSM SHALL have exactly two states: RUN and HANDLER.
REQ-019 Per cycle, next-PC SHALL be selected with priority: reset > exc_req (RUN only) > eret (HANDLER only) > branch_taken > stall > pc+4.
REQ-020 exc_req in RUN: next cycle pc=EXC_VECTOR, elr=exc_pc, esr=exc_cause, state=HANDLER, flush=1; this overrides stall and branch_taken.
REQ-021 exc_req in HANDLER SHALL be ignored (no nesting); elr and esr are unchanged; normal selection applies.
REQ-022 eret in HANDLER: next cycle pc=elr, state=RUN, flush=1; this overrides stall and branch_taken.
REQ-023 eret in RUN SHALL be ignored.
REQ-024 exc_req and eret both high in HANDLER: eret SHALL win.
REQ-025 exc_req and eret both high in RUN: exc_req SHALL win.
REQ-026 branch_taken with no higher-priority event: next pc=branch_target, flush=1, regardless of stall.
REQ-027 stall with no higher-priority event: pc SHALL hold, flush=0.
REQ-028 Default: pc <= pc+4, modulo 2^N (wraps silently).
REQ-029 imem_addr SHALL be combinational from pc (pc[7:2]), so instruction data is valid in the same cycle; imem_addr wraps every 256 bytes.
REQ-030 flush SHALL be registered and high exactly in the cycle the redirected pc is presented.
REQ-031 The low bits of branch_target and elr SHALL be used unmodified; no alignment check.
REQ-032 in_handler SHALL be registered, equal to (state==HANDLER).

Reset
REQ-033 On reset, the next edge SHALL give pc=0, elr=0, esr=0, state=RUN, in_handler=0, flush=0.
REQ-034 Reset SHALL override all inputs, including mid-handler and in the cycle exc_req is asserted.

Verification
REQ-035 Reset then 4 free-running cycles: pc 0,4,8,12; imem_addr 0,1,2,3; flush=0.
REQ-036 At pc=0x40, pulse exc_req with exc_pc=0x44, cause=4'h3, stall=1: next pc=0xD8, imem_addr=54, elr=0x44, esr=3, in_handler=1, flush=1.
REQ-037 In HANDLER, pulse exc_req with cause=5, then eret: elr remains 0x44 and esr 3; after eret pc=0x44, in_handler=0, flush=1.
REQ-038 branch_taken with target 0x80 and stall both high: next pc=0x80, flush=1; stall alone then holds pc=0x80 for 3 cycles.
REQ-039 pc=0xFFFF_FFFF_FFFF_FFFC free-running: next pc=0, imem_addr=0.
REQ-040 Reset asserted in HANDLER with exc_req=1: next pc=0, state RUN, elr=0, esr=0.
